// File: rtl/alu_pipe_muldiv.sv
// Registered RV32I/M execute ALU: one-hot select, pipelined multiply, iterative radix-2 divide.
// Define ALU_MULDIV_EN to build multiply/divide; otherwise bits 11-18 act as illegal selects.
module alu_pipe_muldiv #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned OPS        = 19
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [OPS-1:0]  alu_fun_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned SW = $clog2(XLEN);

    logic [SW-1:0]   shamt;
    logic            one_hot;
    logic            accept;
    logic [XLEN-1:0] base_res [11];
    logic [XLEN-1:0] base_sel;
    logic            valid_q;
    logic [XLEN-1:0] res_q;

    assign shamt   = op2_i[SW-1:0];
    assign one_hot = (alu_fun_i != '0) && ((alu_fun_i & (alu_fun_i - OPS'(1))) == '0);
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        base_res[0]  = op1_i + op2_i;
        base_res[1]  = op1_i << shamt;
        base_res[2]  = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
        base_res[3]  = {{(XLEN-1){1'b0}}, op1_i < op2_i};
        base_res[4]  = op1_i ^ op2_i;
        base_res[5]  = op1_i >> shamt;
        base_res[6]  = op1_i | op2_i;
        base_res[7]  = op1_i & op2_i;
        base_res[8]  = op1_i - op2_i;
        base_res[9]  = $signed(op1_i) >>> shamt;
        base_res[10] = op1_i;
    end

    // XOR-reduce of masked results; only bits 0-10 contribute, so M-ops read 0 here.
    always_comb begin
        base_sel = '0;
        for (int i = 0; i < 11; i++) begin
            base_sel = base_sel ^ (base_res[i] & {XLEN{alu_fun_i[i]}});
        end
        if (!one_hot) begin
            base_sel = '0;
        end
    end

`ifndef ALU_MULDIV_EN

    assign ready_o  = 1'b1;
    assign valid_o  = valid_q;
    assign result_o = res_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                res_q <= base_sel;
            end
        end
    end

`else

    typedef enum logic [2:0] {StIdle, StMul, StDivInit, StDivIter, StDivDone} state_e;

    localparam logic [SW:0]     CntOne   = (SW+1)'(1);
    localparam logic [SW:0]     MulLast  = (SW+1)'(MUL_STAGES);
    localparam logic [SW:0]     IterLast = (SW+1)'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [SW:0]       cnt_q, cnt_d;
    logic              is_mul, is_div, div_special;
    logic              start_mul, start_div, quick;
    logic [XLEN-1:0]   special_res, quick_res;
    logic              mul_s1, mul_s2;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
    logic [XLEN-1:0]   mul_sel;
    logic [XLEN-1:0]   mul_pipe_q [MUL_STAGES];
    logic              mul_done, div_done;
    logic [XLEN-1:0]   dvd_q, dvs_q, quo_q, rem_q;
    logic              div_signed_q, div_rem_q, neg_quo_q, neg_rem_q;
    logic [XLEN:0]     shifted, trial;
    logic [XLEN-1:0]   div_fix;

    assign is_mul = one_hot && (alu_fun_i[14:11] != '0);
    assign is_div = one_hot && (alu_fun_i[18:15] != '0);

    // Divide by zero and signed overflow finish immediately instead of entering the FSM.
    always_comb begin
        div_special = 1'b0;
        special_res = '0;
        if (op2_i == '0) begin
            div_special = 1'b1;
            special_res = (alu_fun_i[15] || alu_fun_i[16]) ? '1 : op1_i;
        end else if ((alu_fun_i[15] || alu_fun_i[17]) && op1_i == MinNeg && op2_i == '1) begin
            div_special = 1'b1;
            special_res = alu_fun_i[15] ? op1_i : '0;
        end
    end

    assign start_mul = accept && is_mul;
    assign start_div = accept && is_div && !div_special;
    assign quick     = accept && !start_mul && !start_div;
    assign quick_res = is_div ? special_res : base_sel;

    // Operands sign-extended to 2*XLEN so one signed multiply covers all four variants.
    assign mul_s1   = alu_fun_i[11] || alu_fun_i[12] || alu_fun_i[13];
    assign mul_s2   = alu_fun_i[11] || alu_fun_i[12];
    assign mul_a    = {{XLEN{mul_s1 & op1_i[XLEN-1]}}, op1_i};
    assign mul_b    = {{XLEN{mul_s2 & op2_i[XLEN-1]}}, op2_i};
    assign mul_full = $signed(mul_a) * $signed(mul_b);
    assign mul_sel  = alu_fun_i[11] ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign div_fix = div_rem_q ? (neg_rem_q ? -rem_q : rem_q) : (neg_quo_q ? -quo_q : quo_q);

    assign ready_o  = (state_q == StIdle);
    assign mul_done = (state_q == StMul) && (cnt_q == MulLast);
    assign div_done = (state_q == StDivDone);
    assign valid_o  = valid_q || mul_done || div_done;

    always_comb begin
        result_o = res_q;
        if (mul_done) begin
            result_o = mul_pipe_q[MUL_STAGES-1];
        end else if (div_done) begin
            result_o = div_fix;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_mul) begin
                    state_d = StMul;
                    cnt_d   = CntOne;
                end else if (start_div) begin
                    state_d = StDivInit;
                end
            end
            StMul: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == MulLast) begin
                    state_d = StIdle;
                end
            end
            StDivInit: begin
                cnt_d   = '0;
                state_d = StDivIter;
            end
            StDivIter: begin
                cnt_d = cnt_q + CntOne;
                if (cnt_q == IterLast) begin
                    state_d = StDivDone;
                end
            end
            StDivDone: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= quick;
            if (quick) begin
                res_q <= quick_res;
            end else if (mul_done || div_done) begin
                res_q <= result_o;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_mul) begin
            mul_pipe_q[0] <= mul_sel;
        end
        for (int i = 1; i < MUL_STAGES; i++) begin
            mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        case (state_q)
            StIdle: begin
                if (start_div) begin
                    dvd_q        <= op1_i;
                    dvs_q        <= op2_i;
                    div_signed_q <= alu_fun_i[15] || alu_fun_i[17];
                    div_rem_q    <= alu_fun_i[17] || alu_fun_i[18];
                end
            end
            StDivInit: begin
                quo_q     <= (div_signed_q && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
                dvs_q     <= (div_signed_q && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
                rem_q     <= '0;
                neg_quo_q <= div_signed_q && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                neg_rem_q <= div_signed_q && dvd_q[XLEN-1];
            end
            StDivIter: begin
                quo_q <= {quo_q[XLEN-2:0], !trial[XLEN]};
                rem_q <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            end
            default: ;
        endcase
    end

`endif

endmodule

// File: tb/tb_alu_pipe_muldiv.sv
// Randomized self-checking bench for alu_pipe_muldiv against an arithmetic reference model.
// Honours ALU_MULDIV_EN the same way the design does.
module tb_alu_pipe_muldiv;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_STAGES = 2;
    localparam int unsigned OPS        = 19;
`ifdef ALU_MULDIV_EN
    localparam bit MulDivEn = 1'b1;
`else
    localparam bit MulDivEn = 1'b0;
`endif

    localparam logic [18:0] FnAdd  = 19'h00001;
    localparam logic [18:0] FnSra  = 19'h00200;
    localparam logic [18:0] FnMul  = 19'h00800;
    localparam logic [18:0] FnMulh = 19'h01000;
    localparam logic [18:0] FnMulhu= 19'h04000;
    localparam logic [18:0] FnDiv  = 19'h08000;
    localparam logic [18:0] FnDivu = 19'h10000;
    localparam logic [18:0] FnRem  = 19'h20000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            valid_in;
    logic            ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [OPS-1:0]  fun;
    logic            valid_out;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_pipe_muldiv #(
        .XLEN      (XLEN),
        .MUL_STAGES(MUL_STAGES),
        .OPS       (OPS)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flush_i  (flush),
        .valid_i  (valid_in),
        .ready_o  (ready),
        .op1_i    (op1),
        .op2_i    (op2),
        .alu_fun_i(fun),
        .valid_o  (valid_out),
        .result_o (result)
    );

`ifndef ALU_MULDIV_EN
    int ready_low = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready !== 1'b1) ready_low++;
    end
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [18:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        int               sa;
        int               sb;
        int               k;
        longint           p;
        longint unsigned  pu;
        sa = a;
        sb = b;
        if ($countones(f) != 1) return '0;
        k = $clog2(f);
        if (k > 10 && !MulDivEn) return '0;
        case (k)
            0:  return a + b;
            1:  return a << b[4:0];
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a ^ b;
            5:  return a >> b[4:0];
            6:  return a | b;
            7:  return a & b;
            8:  return a - b;
            9:  return sa >>> b[4:0];
            10: return a;
            11: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            12: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            13: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            14: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            15: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            17: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                return sa % sb;
            end
            18: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [18:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        bit legal;
        bit ovf;
        legal = ($countones(f) == 1) && MulDivEn;
        ovf   = (f[15] || f[17]) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        if (legal && f[14:11] != 0) return MUL_STAGES;
        if (legal && f[18:15] != 0 && b != 0 && !ovf) return XLEN + 2;
        return 1;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the result pulse.
    task automatic run_op(input string tag, input logic [18:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp_r;
        int          exp_l;
        int          lat;
        int          rdy_hi;
        bit          mul_op;
        exp_r  = ref_res(f, a, b);
        exp_l  = ref_lat(f, a, b);
        mul_op = (exp_l > 1) && (f[14:11] != 0);
        check_eq({tag, " ready_idle"}, 64'(ready), 64'd1);
        fun      = f;
        op1      = a;
        op2      = b;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        fun      = 19'($urandom);
        op1      = $urandom;
        op2      = $urandom;
        lat      = 1;
        rdy_hi   = 0;
        while (valid_out !== 1'b1 && lat < 64) begin
            if (ready) rdy_hi++;
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_l));
        check_eq({tag, " result"}, 64'(result), 64'(exp_r));
        if (exp_l > 1) check_eq({tag, " busy_ready"}, 64'(rdy_hi), 64'd0);
        if (mul_op) check_eq({tag, " ready_at_valid"}, 64'(ready), 64'd0);
        else if (exp_l == 1) check_eq({tag, " ready_at_valid"}, 64'(ready), 64'd1);
        @(negedge clk);
        check_eq({tag, " pulse_end"}, 64'(valid_out), 64'd0);
        check_eq({tag, " hold"}, 64'(result), 64'(exp_r));
    endtask

    task automatic pick_operand(output logic [31:0] v);
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h0000_0001;
        case ($urandom_range(0, 3))
            0:       v = corner[$urandom_range(0, 3)];
            1:       v = $urandom_range(0, 15);
            2:       v = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int highs;
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            if (valid_out !== 1'b0) highs++;
            @(negedge clk);
        end
        check_eq({tag, " no_valid"}, 64'(highs), 64'd0);
    endtask

    initial begin
        logic [18:0] f;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        fun      = '0;
        op1      = '0;
        op2      = '0;
        repeat (3) @(negedge clk);
        check_eq("reset valid_o", 64'(valid_out), 64'd0);
        check_eq("reset result_o", 64'(result), 64'd0);
        check_eq("reset ready_o", 64'(ready), 64'd1);
        rst_n = 1'b1;

        // Back-to-back base ops.
        fun = FnAdd; op1 = 32'h7FFF_FFFF; op2 = 32'h1; valid_in = 1'b1;
        @(negedge clk);
        check_eq("b2b add valid", 64'(valid_out), 64'd1);
        check_eq("b2b add result", 64'(result), 64'h8000_0000);
        check_eq("b2b ready", 64'(ready), 64'd1);
        fun = FnSra; op1 = 32'h8000_0000; op2 = 32'd4;
        @(negedge clk);
        valid_in = 1'b0;
        check_eq("b2b sra valid", 64'(valid_out), 64'd1);
        check_eq("b2b sra result", 64'(result), 64'hF800_0000);
        @(negedge clk);
        check_eq("b2b idle valid", 64'(valid_out), 64'd0);

        run_op("mulh", FnMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu", FnMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div", FnDiv, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", FnRem, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", FnDivu, 32'd100, 32'd7);
        run_op("divu_by0", FnDivu, 32'd5, 32'd0);
        run_op("rem_by0", FnRem, 32'd5, 32'd0);
        run_op("div_ovf", FnDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("illegal", 19'h00003, 32'd9, 32'd4);
        run_op("mul", FnMul, 32'd3, 32'd4);

        // Flush on the accept edge inhibits the accept.
        fun = FnAdd; op1 = 32'd2; op2 = 32'd3; valid_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        check_eq("flush_accept valid", 64'(valid_out), 64'd0);
        check_eq("flush_accept ready", 64'(ready), 64'd1);
        quiet_window("flush_accept", 3);
        run_op("add_after_flush", FnAdd, 32'd2, 32'd3);

`ifdef ALU_MULDIV_EN
        // Kill a divide mid-iteration, first by flush then by reset.
        for (int pass = 0; pass < 2; pass++) begin
            fun = FnDiv; op1 = 32'hFFFF_FFF9; op2 = 32'd2; valid_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            repeat (11) @(negedge clk);
            if (pass == 0) flush = 1'b1;
            else rst_n = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            rst_n = 1'b1;
            check_eq(pass == 0 ? "div_flush ready" : "div_reset ready", 64'(ready), 64'd1);
            if (pass == 1) check_eq("div_reset result", 64'(result), 64'd0);
            quiet_window(pass == 0 ? "div_flush" : "div_reset", 40);
            run_op(pass == 0 ? "add_after_div_flush" : "add_after_div_reset", FnAdd, 32'd2,
                   32'd3);
        end

        // Kill a multiply before its result appears.
        fun = FnMul; op1 = 32'd6; op2 = 32'd7; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("mul_flush ready", 64'(ready), 64'd1);
        quiet_window("mul_flush", 6);
`endif

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 19);
            if (sel == 19) f = 19'($urandom);
            else f = 19'(1) << sel;
            pick_operand(a);
            pick_operand(b);
            run_op($sformatf("rand%0d", n), f, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

`ifndef ALU_MULDIV_EN
        check_eq("ready_const", 64'(ready_low), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_pipe_muldiv.md
Name: alu_pipe_muldiv

Overview:
Registered, parametrised successor of the single-cycle one-hot ALU for the RV32I/M execute stage. It keeps the one-hot function select (XOR-reduced result selection) for the 11 base ops and adds the 8 RV M-extension ops. Multiply runs in a fixed-depth pipeline and divide/remainder in an iterative radix-2 FSM. A valid/ready handshake and a flush input interface with the hazard unit; the block sits between the ID/EX register and the EX/MEM register.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_STAGES, 2, multiply latency in cycles (1..4), register stages after the product
OPS, 19, width of alu_fun_i; fixed, not to be overridden

Ports:
clk_i  input  1  rising-edge clock
rst_ni  input  1  synchronous active-low reset
flush_i  input  1  abort in-flight op (pipeline kill)
valid_i  input  1  op1_i/op2_i/alu_fun_i valid this cycle
ready_o  output  1  block can accept an op this cycle
op1_i  input  XLEN  operand 1
op2_i  input  XLEN  operand 2
alu_fun_i  input  OPS  one-hot function select
valid_o  output  1  result_o valid; one-cycle pulse per accepted op
result_o  output  XLEN  result

Behaviour:
- Reset: synchronous on rst_ni=0. valid_o=0, result_o=0, ready_o=1 from the first cycle after reset. Reset mid-operation discards the op with no valid_o.
- alu_fun_i bits: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA, 10 PASS(op1, LUI), 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
- Shift amount: op2_i[log2(XLEN)-1:0]. Add/sub wrap modulo 2^XLEN. SLT/SLTU yield zero-extended 0/1.
- Accept: occurs on a clock edge where valid_i & ready_o & !flush_i.
- Illegal select: alu_fun_i=0 or non-one-hot is accepted and returns 0 at base latency.
- Base ops (bits 0-10): latency 1. valid_o is high in the cycle after accept. ready_o stays 1, so back-to-back accepts are allowed every cycle.
- Multiply (bits 11-14): full 2*XLEN product. MUL returns the low half; the others return the high half with the appropriate signedness (MULHSU: op1 signed, op2 unsigned). Latency MUL_STAGES. ready_o=0 from the cycle after accept until the cycle valid_o is high, inclusive.
- Divide (bits 15-18): FSM states IDLE -> DIV_INIT -> DIV_ITER -> DIV_DONE -> IDLE.
  - DIV_INIT: takes absolute values for signed ops and records sign flags.
  - DIV_ITER: runs exactly XLEN restoring iterations, one per cycle, on a log2(XLEN)+1-bit counter.
  - DIV_DONE: applies sign fixup (quotient sign = sign1^sign2; remainder sign = sign of dividend) and drives valid_o.
  - Latency: XLEN+2 cycles from accept. ready_o=0 from the cycle after accept until valid_o is high.
- Divide special cases resolve in IDLE at latency 1, bypassing the FSM:
  - divisor 0: quotient all-ones, remainder = op1.
  - signed overflow (op1 = most-negative, op2 = -1): quotient = op1, remainder 0.
- Results return in order. valid_o is never high two cycles in a row for a multicycle op.
- result_o holds its last value while valid_o=0.
- flush_i=1 at an edge:
  - Cancels any in-flight mul/div; no valid_o follows.
  - Inhibits an accept on that same edge.
  - The state returns to IDLE, with ready_o=1 next cycle.
  - Flushing in the cycle where valid_o is already high does not retract that output.
- ready_o is combinational from state only, not from valid_i.

Optional Feature:
ALU_MULDIV_EN
- Defined: full behaviour above.
- Undefined: multiply pipeline and divide FSM are not compiled. Bits 11-18 are treated as illegal selects (return 0, latency 1). ready_o is tied to 1.

Test Plan:
- Base op: XLEN=32, ADD 0x7FFFFFFF+1 then SRA 0x80000000>>>4 on consecutive cycles -> valid_o on the next two cycles with 0x80000000, then 0xF8000000.
- MULH/MULHU with op1=0xFFFFFFFF, op2=0xFFFFFFFF, MUL_STAGES=2:
  - MULH -> 0x00000000 two cycles after accept.
  - MULHU -> 0xFFFFFFFE.
  - ready_o=0 in between.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD at XLEN+2=34 cycles.
  - REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
- Special cases:
  - DIVU x/0 with op1=5 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000.
  - All three at latency 1.
- Flush/reset:
  - Start DIV, assert flush_i at iteration 10 -> no valid_o; ready_o=1 next cycle; a following ADD 2+3 returns 5 at latency 1.
  - Repeat with rst_ni=0 instead of flush_i -> same.
- Illegal select, plus ALU_MULDIV_EN undefined:
  - alu_fun_i=0x00003 -> result 0, latency 1.
  - With the macro undefined, MUL 3*4 -> 0, latency 1, ready_o constant 1.
